// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multicycle MIPS control FSM: state encoding, opcodes,
// control-field encodings and the packed control-word struct.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_LOGI_EX  = 4'd10,
    S_LUI_EX   = 4'd11,
    S_IMM_WB   = 4'd12,
    S_JUMP     = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGI  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [1:0] ext_op;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-word decoder: current state (plus mem_ready in FETCH)
// to datapath control signals.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ_EX: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDI_EX, S_LUI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ext_op    = (state == S_LUI_EX) ? EXT_LUI : EXT_SIGN;
      end
      S_LOGI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_LOGI;
        ctrl.ext_op    = EXT_ZERO;
      end
      S_IMM_WB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: state register, next-state logic and retired
// instruction counter. Define MIPS_ILLEGAL_TRAP_EN to trap on unknown opcodes.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [1:0]       ext_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_op
);

  state_t state, next_state;
  ctrl_t  ctrl, ctrl_gated;
  logic   retire;

  // funct goes straight to the ALU decoder and zero is combined with
  // pc_write_cond in the datapath; neither steers this FSM.
  logic unused_inputs;
  assign unused_inputs = ^{funct, zero};

  always_comb begin
    next_state = S_FETCH;
    unique case (state)
      S_FETCH: next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (opcode)
          OP_RTYPE:        next_state = S_RTYPE_EX;
          OP_LW, OP_SW:    next_state = S_MEMADR;
          OP_BEQ:          next_state = S_BEQ_EX;
          OP_ADDI:         next_state = S_ADDI_EX;
          OP_ANDI, OP_ORI: next_state = S_LOGI_EX;
          OP_LUI:          next_state = S_LUI_EX;
          OP_J:            next_state = S_JUMP;
          default:         next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: next_state = S_RTYPE_WB;
      S_ADDI_EX, S_LOGI_EX, S_LUI_EX: next_state = S_IMM_WB;
`ifdef MIPS_ILLEGAL_TRAP_EN
      S_ILLEGAL:  next_state = S_ILLEGAL;
`else
      S_ILLEGAL:  next_state = S_FETCH;
`endif
      default:    next_state = S_FETCH;
    endcase
  end

  // FETCH stalls hold in FETCH, so only a state change into FETCH is a retire.
  assign retire = (state != S_FETCH) && (next_state == S_FETCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

`ifdef MIPS_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)                         illegal_op <= 1'b0;
    else if (next_state == S_ILLEGAL)  illegal_op <= 1'b1;
  end
`else
  assign illegal_op = 1'b0;
`endif

  mips_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign ctrl_gated = reset ? '0 : ctrl;

  assign pc_write      = ctrl_gated.pc_write;
  assign pc_write_cond = ctrl_gated.pc_write_cond;
  assign iord          = ctrl_gated.iord;
  assign mem_read      = ctrl_gated.mem_read;
  assign mem_write     = ctrl_gated.mem_write;
  assign ir_write      = ctrl_gated.ir_write;
  assign reg_dst       = ctrl_gated.reg_dst;
  assign mem_to_reg    = ctrl_gated.mem_to_reg;
  assign reg_write     = ctrl_gated.reg_write;
  assign alu_src_a     = ctrl_gated.alu_src_a;
  assign alu_src_b     = ctrl_gated.alu_src_b;
  assign alu_op        = ctrl_gated.alu_op;
  assign pc_source     = ctrl_gated.pc_source;
  assign ext_op        = ctrl_gated.ext_op;
  assign state_o       = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl (CNT_W=4); expected per-cycle outputs
// go through a scoreboard queue and are checked with immediate assertions.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, zero, mem_ready;
  logic [5:0]       opcode, funct;
  logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic             reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source, ext_op;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instr_count;
  logic             illegal_op;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .ext_op(ext_op), .state_o(state_o),
    .instr_count(instr_count), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       st;
    logic [17:0]      ctrl;
    logic [CNT_W-1:0] cnt;
    logic             ill;
    logic             chk_sc;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             exp_ill = 1'b0;
  logic [17:0]      obs_ctrl;

  assign obs_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                     reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source, ext_op};

  // Control word expected in each state, written from the behavioural table.
  function automatic logic [17:0] exp_ctrl(state_t s, logic mr, logic rst);
    logic pcw, pcwc, io, mrd, mwr, irw, rd, m2r, rw, sa;
    logic [1:0] sbx, op, ps, ext;
    {pcw, pcwc, io, mrd, mwr, irw, rd, m2r, rw, sa} = '0;
    {sbx, op, ps, ext} = '0;
    if (!rst) begin
      case (s)
        S_FETCH:    begin mrd = 1; sbx = 2'b01; irw = mr; pcw = mr; end
        S_DECODE:   sbx = 2'b11;
        S_MEMADR:   begin sa = 1; sbx = 2'b10; end
        S_MEMRD:    begin io = 1; mrd = 1; end
        S_MEMWB:    begin rw = 1; m2r = 1; end
        S_MEMWR:    begin io = 1; mwr = 1; end
        S_RTYPE_EX: begin sa = 1; op = 2'b10; end
        S_RTYPE_WB: begin rw = 1; rd = 1; end
        S_BEQ_EX:   begin sa = 1; op = 2'b01; pcwc = 1; ps = 2'b01; end
        S_ADDI_EX:  begin sa = 1; sbx = 2'b10; end
        S_LOGI_EX:  begin sa = 1; sbx = 2'b10; op = 2'b11; ext = 2'b01; end
        S_LUI_EX:   begin sa = 1; sbx = 2'b10; ext = 2'b10; end
        S_IMM_WB:   rw = 1;
        S_JUMP:     begin pcw = 1; ps = 2'b10; end
        default:    ;
      endcase
    end
    return {pcw, pcwc, io, mrd, mwr, irw, rd, m2r, rw, sa, sbx, op, ps, ext};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after a falling edge, sample 1 ns later.
  task automatic cyc(input logic rst, input logic [5:0] op, input logic mr,
                     input logic z, input state_t st, input bit ret, input bit chk_sc);
    exp_t e, got;
    reset = rst; opcode = op; mem_ready = mr; zero = z; funct = 6'($urandom);
    e.st = st; e.ctrl = exp_ctrl(st, mr, rst); e.cnt = exp_cnt;
    e.ill = exp_ill; e.chk_sc = chk_sc;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    check({"ctrl@", st.name()}, 32'(obs_ctrl), 32'(got.ctrl));
    if (got.chk_sc) begin
      check({"state@", st.name()}, 32'(state_o), 32'(got.st));
      check({"count@", st.name()}, 32'(instr_count), 32'(got.cnt));
      check({"illegal@", st.name()}, 32'(illegal_op), 32'(got.ill));
    end
    if (rst) begin
      exp_cnt = '0;
      exp_ill = 1'b0;
    end else if (ret) begin
      exp_cnt = exp_cnt + 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic run_jump();
    cyc(0, OP_J, 1, 0, S_FETCH, 0, 1);
    cyc(0, OP_J, 1, 0, S_DECODE, 0, 1);
    cyc(0, OP_J, 1, 0, S_JUMP, 1, 1);
  endtask

  task automatic run_imm(input logic [5:0] op, input state_t ex, input logic mr_mid);
    cyc(0, op, 1, 0, S_FETCH, 0, 1);
    cyc(0, op, mr_mid, 0, S_DECODE, 0, 1);
    cyc(0, op, mr_mid, 0, ex, 0, 1);
    cyc(0, op, mr_mid, 0, S_IMM_WB, 1, 1);
  endtask

  task automatic run_beq(input logic z);
    cyc(0, OP_BEQ, 1, z, S_FETCH, 0, 1);
    cyc(0, OP_BEQ, 1, z, S_DECODE, 0, 1);
    cyc(0, OP_BEQ, 1, z, S_BEQ_EX, 1, 1);
  endtask

  initial begin
    // Reset with mem_ready high: everything off; state is unknown before the first edge.
    cyc(1, OP_J, 1, 0, S_FETCH, 0, 0);
    cyc(1, OP_J, 1, 0, S_FETCH, 0, 1);

    // LW with a three-cycle stall in MEMRD: eight cycles.
    cyc(0, OP_LW, 1, 0, S_FETCH, 0, 1);
    cyc(0, OP_LW, 1, 0, S_DECODE, 0, 1);
    cyc(0, OP_LW, 1, 0, S_MEMADR, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, OP_LW, 0, 0, S_MEMRD, 0, 1);
    cyc(0, OP_LW, 1, 0, S_MEMRD, 0, 1);
    cyc(0, OP_LW, 1, 0, S_MEMWB, 1, 1);

    // ORI with mem_ready low where it must be ignored, then LUI.
    run_imm(OP_ORI, S_LOGI_EX, 0);
    run_imm(OP_LUI, S_LUI_EX, 1);

    run_beq(1);
    run_beq(0);

    // R-type behind a fetch stall (no ir_write/pc_write while stalled).
    cyc(0, OP_RTYPE, 0, 0, S_FETCH, 0, 1);
    cyc(0, OP_RTYPE, 1, 0, S_FETCH, 0, 1);
    cyc(0, OP_RTYPE, 1, 0, S_DECODE, 0, 1);
    cyc(0, OP_RTYPE, 1, 0, S_RTYPE_EX, 0, 1);
    cyc(0, OP_RTYPE, 1, 0, S_RTYPE_WB, 1, 1);

    run_imm(OP_ADDI, S_ADDI_EX, 1);
    run_imm(OP_ANDI, S_LOGI_EX, 1);

    // SW with a one-cycle stall in MEMWR.
    cyc(0, OP_SW, 1, 0, S_FETCH, 0, 1);
    cyc(0, OP_SW, 1, 0, S_DECODE, 0, 1);
    cyc(0, OP_SW, 1, 0, S_MEMADR, 0, 1);
    cyc(0, OP_SW, 0, 0, S_MEMWR, 0, 1);
    cyc(0, OP_SW, 1, 0, S_MEMWR, 1, 1);

    // Unknown opcode.
    cyc(0, 6'b111111, 1, 0, S_FETCH, 0, 1);
    cyc(0, 6'b111111, 1, 0, S_DECODE, 0, 1);
`ifdef MIPS_ILLEGAL_TRAP_EN
    exp_ill = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 6'b111111, 1, 0, S_ILLEGAL, 0, 1);
    cyc(1, OP_J, 1, 0, S_ILLEGAL, 0, 1);
`else
    cyc(0, 6'b111111, 1, 0, S_ILLEGAL, 1, 1);
    cyc(0, OP_J, 1, 0, S_FETCH, 0, 1);
    cyc(1, OP_J, 1, 0, S_DECODE, 0, 1);
`endif

    // Sixteen jumps from zero wrap the 4-bit counter.
    for (int i = 0; i < 16; i++) run_jump();
    run_jump();

    // Reset during a MEMWR stall aborts the store without a retire.
    cyc(0, OP_SW, 1, 0, S_FETCH, 0, 1);
    cyc(0, OP_SW, 1, 0, S_DECODE, 0, 1);
    cyc(0, OP_SW, 1, 0, S_MEMADR, 0, 1);
    cyc(0, OP_SW, 0, 0, S_MEMWR, 0, 1);
    cyc(1, OP_SW, 1, 0, S_MEMWR, 0, 1);
    cyc(0, OP_SW, 0, 0, S_FETCH, 0, 1);
    cyc(0, OP_SW, 1, 0, S_FETCH, 0, 1);
    cyc(0, OP_SW, 1, 0, S_DECODE, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
